cenn_image_loader: RTL
======================

Name: cenn_image_loader

Overview:
Sequences loading of one grayscale frame into the CeNN PE array. Reads pixels from the image memory in raster order and feeds them to the external uint-to-fixed converter (gray -> 1 - 2*gray/256, 15-bit fixed). Re-aligns each converted value with its row/column across the converter's fixed pipeline latency and issues one write strobe per PE. Sits between the frame memory, the converter and the PE array; the top-level controller triggers it once per frame.

Parameters:
IMG_W, 16, image width in pixels (>=2)
IMG_H, 16, image height in pixels (>=2)
WIDTH_UINT, 8, pixel width
WIDTH_FIXED, 15, converter output width
ADDR_W, 8, memory address width; IMG_W*IMG_H <= 2**ADDR_W
CONV_LAT, 4, converter latency: cycles from gray presented to fixed valid

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; begin frame load
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last PE write
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  pixel address, row*IMG_W+col
mem_rd_data  in  WIDTH_UINT  pixel; valid 1 cycle after mem_rd_en
conv_gray  out  WIDTH_UINT  to converter; combinational copy of mem_rd_data
conv_ready  in  1  converter warm-up complete
conv_fixed  in  WIDTH_FIXED  converter output
pe_wr_en  out  1  PE write strobe
pe_row  out  $clog2(IMG_H)  target row
pe_col  out  $clog2(IMG_W)  target column
pe_data  out  WIDTH_FIXED  fixed-point value to write

Behaviour:
- Clock clk; reset rst is asynchronous and active-high. Reset clears all state. State returns to IDLE. busy, done, mem_rd_en, pe_wr_en, mem_addr, pe_row, pe_col and pe_data all reset to 0. The alignment pipe is cleared.
- FSM states: IDLE, WARM, STREAM, DRAIN, DONE.
- IDLE: waits for start. Goes to WARM and sets busy=1. A start pulse is ignored in any other state.
- WARM: waits for conv_ready=1, then goes to STREAM. If conv_ready is already 1, WARM lasts exactly one cycle.
- STREAM: asserts mem_rd_en every cycle, with mem_addr = 0,1,...,IMG_W*IMG_H-1. The row/column counters advance with col wrap-around: col wraps from IMG_W-1 to 0 and row increments. After the address of the last pixel is issued, the block goes to DRAIN.
- Alignment pipe: a shift register of depth 1+CONV_LAT carries {valid,row,col}. At pipe exit, pe_data<=conv_fixed, pe_row/pe_col<=the carried coordinates, and pe_wr_en<=valid, all registered.
- Latency: read issued in cycle t -> pe_wr_en in cycle t+CONV_LAT+2 (t+6 at default). Writes are back-to-back with no gaps, in raster order, exactly IMG_W*IMG_H strobes per frame.
- DRAIN: waits until the pipe is empty. done pulses in the same cycle as the final pe_wr_en. The block then enters DONE.
- DONE: lasts one cycle. busy drops and the block returns to IDLE. A new start is accepted in the cycle after DONE.
- pe_row, pe_col and pe_data hold their last values when pe_wr_en=0.
- If conv_ready falls during STREAM, it is ignored; the converter's ready is sticky.
- Reset mid-frame aborts the frame immediately. No further pe_wr_en is issued, and done is not pulsed.
- No backpressure: the PE array must accept one write per cycle.

Optional Feature:
CENN_LOAD_CHECKSUM_EN.
- Defined: adds output checksum [WIDTH_FIXED+ADDR_W-1:0]. It is a two's-complement sum of the sign-extended pe_data over every write of the frame.
- The accumulator clears on an accepted start. checksum is valid and stable from the done pulse until the next start, and resets to 0.
- Undefined: the port and the accumulator are absent. Behaviour is otherwise identical.

Decomposition:
- Package cenn_pkg holds the following shared items:
  - state enum loader_state_t {IDLE,WARM,STREAM,DRAIN,DONE}.
  - Constants IMG_W, IMG_H, WIDTH_UINT, WIDTH_FIXED and CONV_LAT.
  - FIXED_ONE = 15'h0200, i.e. 1.0 with 9 fractional bits.
- One sub-module: cenn_coord_delay, a parameterised shift register carrying {valid,row,col} over CONV_LAT+1 stages.

Test Plan:
- 4x4 image, all pixels 0, conv_ready high -> 16 pe_wr_en strobes, pe_data=15'h0200 each, raster order (0,0)..(3,3), done coincident with the 16th strobe.
- Pixel values 0, 128, 255 at addresses 0, 1, 2 -> pe_data 15'h0200, 15'h0000, 15'h7E04 at (0,0), (0,1), (0,2). The first strobe comes 6 cycles after the first mem_rd_en.
- conv_ready held low for 10 cycles after start -> no mem_rd_en during that time; streaming starts the cycle after conv_ready rises.
- start pulsed again mid-frame -> ignored; exactly IMG_W*IMG_H writes and one done.
- rst asserted after 5 writes -> all outputs 0 asynchronously, no further strobes, no done; a following start loads the full frame correctly.
- CENN_LOAD_CHECKSUM_EN with 4x4 all-128 -> checksum=0; with all-0 -> checksum=16*0x200=0x2000.

Source files
------------

// File: rtl/cenn_pkg.sv
// cenn_pkg: shared loader state type, default frame geometry and converter constants.
package cenn_pkg;
  typedef enum logic [2:0] {IDLE, WARM, STREAM, DRAIN, DONE} loader_state_t;
  localparam int IMG_W = 16;
  localparam int IMG_H = 16;
  localparam int WIDTH_UINT = 8;
  localparam int WIDTH_FIXED = 15;
  localparam int CONV_LAT = 4;
  localparam logic [14:0] FIXED_ONE = 15'h0200;
endpackage

// File: rtl/cenn_coord_delay.sv
// cenn_coord_delay: fixed-depth shift register carrying a valid flag and a row/col tag.
module cenn_coord_delay #(
  parameter int DEPTH = 5,
  parameter int W = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [W-1:0]     data_i,
  output logic [DEPTH-1:0] vld_o,
  output logic [W-1:0]     data_o
);
  logic [DEPTH-1:0] vld_q;
  logic [W-1:0] dat_q [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], valid_i};
      dat_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) dat_q[i] <= dat_q[i-1];
    end
  assign vld_o = vld_q;
  assign data_o = dat_q[DEPTH-1];
endmodule

// File: rtl/cenn_image_loader.sv
// cenn_image_loader: streams one frame from image memory through the converter into the PE array.
// Define CENN_LOAD_CHECKSUM_EN to add a running two's-complement checksum of all PE writes.
module cenn_image_loader #(
  parameter int IMG_W = cenn_pkg::IMG_W,
  parameter int IMG_H = cenn_pkg::IMG_H,
  parameter int WIDTH_UINT = cenn_pkg::WIDTH_UINT,
  parameter int WIDTH_FIXED = cenn_pkg::WIDTH_FIXED,
  parameter int ADDR_W = 8,
  parameter int CONV_LAT = cenn_pkg::CONV_LAT
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [WIDTH_UINT-1:0]      mem_rd_data,
  output logic [WIDTH_UINT-1:0]      conv_gray,
  input  logic                       conv_ready,
  input  logic [WIDTH_FIXED-1:0]     conv_fixed,
  output logic                       pe_wr_en,
  output logic [$clog2(IMG_H)-1:0]   pe_row,
  output logic [$clog2(IMG_W)-1:0]   pe_col,
  output logic [WIDTH_FIXED-1:0]     pe_data
`ifdef CENN_LOAD_CHECKSUM_EN
  ,
  output logic [WIDTH_FIXED+ADDR_W-1:0] checksum
`endif
);
  import cenn_pkg::*;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int D = CONV_LAT + 1;
  localparam int N = IMG_W * IMG_H;
  loader_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [D-1:0] vld;
  logic [RW+CW-1:0] crd;
  logic streaming, last_pix, col_end;
  assign streaming = state_q == STREAM;
  assign last_pix = addr_q == ADDR_W'(N - 1);
  assign col_end = col_q == CW'(IMG_W - 1);
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign mem_rd_en = streaming;
  assign mem_addr = addr_q;
  assign conv_gray = mem_rd_data;
  // DRAIN ends when only the final pixel remains, sitting at the pipe exit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? WARM : IDLE;
      WARM:    state_d = conv_ready ? STREAM : WARM;
      STREAM:  state_d = last_pix ? DRAIN : STREAM;
      DRAIN:   state_d = (vld == {1'b1, {(D-1){1'b0}}}) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      state_q <= state_d;
      if (streaming) begin
        addr_q <= last_pix ? '0 : addr_q + 1'b1;
        col_q <= col_end ? '0 : col_q + 1'b1;
        row_q <= last_pix ? '0 : col_end ? row_q + 1'b1 : row_q;
      end
    end
  cenn_coord_delay #(.DEPTH(D), .W(RW + CW)) u_dly (
    .clk     (clk),
    .rst     (rst),
    .valid_i (streaming),
    .data_i  ({row_q, col_q}),
    .vld_o   (vld),
    .data_o  (crd)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pe_wr_en <= 1'b0;
      pe_row <= '0;
      pe_col <= '0;
      pe_data <= '0;
    end else begin
      pe_wr_en <= vld[D-1];
      if (vld[D-1]) begin
        {pe_row, pe_col} <= crd;
        pe_data <= conv_fixed;
      end
    end
`ifdef CENN_LOAD_CHECKSUM_EN
  logic [WIDTH_FIXED+ADDR_W-1:0] csum_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) csum_q <= '0;
    else if (state_q == IDLE && start) csum_q <= '0;
    else if (vld[D-1]) csum_q <= csum_q + {{ADDR_W{conv_fixed[WIDTH_FIXED-1]}}, conv_fixed};
  assign checksum = csum_q;
`endif
endmodule
